fp32_norm_pack: RTL

//  Sequential normalize/round/pack stage for the IEEE 754 single-precision math unit. It sits directly

---
 rtl/fp32_norm_pack_if.sv | 28 ++
 rtl/fp32_norm_pack.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_norm_pack_if.sv
// Handshake bundle between the FP datapath, the fp32_norm_pack stage and its consumer.
// The master side drives the unpacked result and accepts the packed word; the slave side is the stage.
interface fp32_norm_pack_if #(
   parameter int MANT_W = 48,
   parameter int EXP_W  = 10
);
   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [EXP_W-1:0]  in_exp;
   logic [MANT_W-1:0] in_mant;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic              out_ovf;
   logic              out_udf;
   logic              out_inx;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, out_ready,
      input  in_ready, out_valid, out_data, out_ovf, out_udf, out_inx
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, out_ready,
      output in_ready, out_valid, out_data, out_ovf, out_udf, out_inx
   );
endinterface

// File: rtl/fp32_norm_pack.sv
// Sequential normalize / round-to-nearest-even / pack stage for IEEE 754 single precision.
// Define FP_DENORM_EN for gradual underflow; the default build flushes tiny results to zero.
module fp32_norm_pack #(
   parameter int MANT_W = 48,
   parameter int EXP_W  = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fp32_norm_pack_if.slave        bus
);
   // Two spare exponent bits absorb up to MANT_W-2 left shifts below the input range.
   localparam int XW = EXP_W + 2;
   localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
   localparam logic signed [XW-1:0] EXP_MAX = XW'(255);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_NORM  = 2'd1;
   localparam logic [1:0] S_ROUND = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            r_state;
   logic                  r_sign;
   logic signed [XW-1:0]  r_exp;
   logic [MANT_W-1:0]     r_mant;
   logic                  r_sticky;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [31:0]           r_out_data;
   logic                  r_ovf;
   logic                  r_udf;
   logic                  r_inx;

   logic                  w_shr;
   logic                  w_shl;
   logic [23:0]           w_sig;
   logic                  w_guard;
   logic                  w_st;
   logic                  w_inc;
   logic [24:0]           w_sum;
   logic [23:0]           w_sig_r;
   logic signed [XW-1:0]  w_exp_r;
   logic                  w_inx_raw;
   logic [31:0]           w_data;
   logic                  w_ovf;
   logic                  w_udf;
   logic                  w_inx;

   // Normalize decision: one right or left shift per cycle, or done.
   always_comb begin
      w_shr = 1'b0;
      w_shl = 1'b0;
      if (r_mant == '0) begin
         w_shr = 1'b0;
      end else if (r_mant[MANT_W-1]) begin
         w_shr = 1'b1;
`ifdef FP_DENORM_EN
      end else if (r_exp < EXP_ONE) begin
         w_shr = 1'b1;
      end else if (!r_mant[MANT_W-2] && (r_exp > EXP_ONE)) begin
         w_shl = 1'b1;
`else
      end else if (!r_mant[MANT_W-2]) begin
         w_shl = 1'b1;
`endif
      end else begin
         w_shl = 1'b0;
      end
   end

   // Round to nearest even on the 24-bit significand below the upper integer bit.
   always_comb begin
      w_sig     = r_mant[MANT_W-2 -: 24];
      w_guard   = r_mant[MANT_W-26];
      w_st      = r_sticky | (|r_mant[MANT_W-27:0]);
      w_inc     = w_guard & (w_st | w_sig[0]);
      w_sum     = {1'b0, w_sig} + {24'd0, w_inc};
      w_inx_raw = w_guard | w_st;
      if (w_sum[24]) begin
         w_sig_r = w_sum[24:1];
         w_exp_r = r_exp + EXP_ONE;
      end else begin
         w_sig_r = w_sum[23:0];
         w_exp_r = r_exp;
      end
   end

   // Pack the rounded value and derive the exception flags.
   always_comb begin
      w_data = 32'h0000_0000;
      w_ovf  = 1'b0;
      w_udf  = 1'b0;
      w_inx  = w_inx_raw;
      if (w_sig_r == 24'd0) begin
         w_data = {r_sign, 31'h0000_0000};
`ifdef FP_DENORM_EN
         w_udf  = (~w_sig[23]) & w_inx_raw;
`endif
      end else if (w_exp_r >= EXP_MAX) begin
         w_data = {r_sign, 8'hFF, 23'h00_0000};
         w_ovf  = 1'b1;
         w_inx  = 1'b1;
`ifdef FP_DENORM_EN
      end else begin
         w_data = {r_sign, (w_sig_r[23] ? w_exp_r[7:0] : 8'h00), w_sig_r[22:0]};
         w_udf  = (~w_sig[23]) & w_inx_raw;
      end
`else
      end else if (w_exp_r < EXP_ONE) begin
         w_data = {r_sign, 31'h0000_0000};
         w_udf  = 1'b1;
         w_inx  = 1'b1;
      end else begin
         w_data = {r_sign, w_exp_r[7:0], w_sig_r[22:0]};
      end
`endif
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_sign      <= 1'b0;
         r_exp       <= '0;
         r_mant      <= '0;
         r_sticky    <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= 32'h0000_0000;
         r_ovf       <= 1'b0;
         r_udf       <= 1'b0;
         r_inx       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_sign     <= bus.in_sign;
                  r_exp      <= {{2{bus.in_exp[EXP_W-1]}}, bus.in_exp};
                  r_mant     <= bus.in_mant;
                  r_sticky   <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_NORM;
               end
            end
            S_NORM: begin
               if (w_shr) begin
                  r_mant   <= r_mant >> 1;
                  r_sticky <= r_sticky | r_mant[0];
                  r_exp    <= r_exp + EXP_ONE;
               end else if (w_shl) begin
                  r_mant <= r_mant << 1;
                  r_exp  <= r_exp - EXP_ONE;
               end else begin
                  r_state <= S_ROUND;
               end
            end
            S_ROUND: begin
               r_out_data  <= w_data;
               r_ovf       <= w_ovf;
               r_udf       <= w_udf;
               r_inx       <= w_inx;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_ovf   = r_ovf;
   assign bus.out_udf   = r_udf;
   assign bus.out_inx   = r_inx;
endmodule
